// File: rtl/alu_exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl_pkg
// Purpose  : Opcode values and FSM state encoding for the execute sequencer.
// Revision : 1.0
// ============================================================================
package alu_exec_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OUT = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EXEC  = 2'd3
    } state_t;

    // Opcodes that need a memory operand and therefore walk the full FSM
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : exec_timeout_ctr
// Purpose  : Saturating cycle counter bounding the wait for memory read data.
// Revision : 1.0
// ============================================================================
module exec_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the last permitted waiting cycle: counts 0..TIMEOUT-1 give TIMEOUT cycles
    assign expired = enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Execute sequencer around an external add/sub ALU; owns ACC and OUT.
// Revision : 1.0
// ============================================================================
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W:0]   alu_res,
    output logic [DATA_W-1:0] acc,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              done,
    output logic              err
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_opcode;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_out_data;
    logic              r_carry;
    logic              r_zero;
    logic              r_out_valid;
    logic              r_done;
    logic              r_err;
    logic              w_accept;
    logic              w_tmo_expired;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);

    exec_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == ST_FETCH),
        .enable  (r_state == ST_WAIT),
        .expired (w_tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        mem_req     = 1'b0;
        alu_op      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (w_accept && is_mem_op(cmd_opcode)) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req     = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Data arriving on the expiry cycle still counts
                if (mem_rvalid) begin
                    w_state_nxt = ST_EXEC;
                end else if (w_tmo_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                alu_op      = (r_opcode == OP_SUB);
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_opcode    <= OP_NOP;
            r_mem_addr  <= '0;
            r_acc       <= '0;
            r_operand   <= '0;
            r_out_data  <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (cmd_opcode)
                            OP_NOP: r_done <= 1'b1;
                            OP_OUT: begin
                                r_out_data  <= r_acc;
                                r_out_valid <= 1'b1;
                                r_done      <= 1'b1;
                            end
                            OP_LDA, OP_ADD, OP_SUB: begin
                                r_opcode   <= cmd_opcode;
                                r_mem_addr <= cmd_addr;
                            end
                            default: begin
                                r_done <= 1'b1;
                                r_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        r_operand <= mem_rdata;
                    end else if (w_tmo_expired) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    r_done <= 1'b1;
                    if (r_opcode == OP_LDA) begin
                        r_acc  <= r_operand;
                        r_zero <= (r_operand == '0);
                    end else begin
                        r_acc   <= alu_res[DATA_W-1:0];
                        r_carry <= alu_res[DATA_W];
                        r_zero  <= (alu_res[DATA_W-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = r_mem_addr;
    assign alu_a      = r_acc;
    assign alu_b      = r_operand;
    assign acc        = r_acc;
    assign carry_flag = r_carry;
    assign zero_flag  = r_zero;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_ctrl
// Purpose  : Directed vector bench for alu_exec_ctrl with a behavioural ALU/memory.
// Revision : 1.0
// ============================================================================
module tb_alu_exec_ctrl;
    import alu_exec_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_opcode = 4'h0;
    logic [3:0] cmd_addr = 4'h0;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_rvalid = 1'b0;
    logic       alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [8:0] alu_res;
    logic [7:0] acc;
    logic       carry_flag;
    logic       zero_flag;
    logic [7:0] out_data;
    logic       out_valid;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // External 8-bit add/sub ALU sitting beside the sequencer
    assign alu_res = alu_op ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});

    alu_exec_ctrl #(.DATA_W(8), .ADDR_W(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode), .cmd_addr(cmd_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
        .acc(acc), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .out_data(out_data), .out_valid(out_valid), .done(done), .err(err)
    );

    typedef struct {
        logic [3:0] op;
        logic [7:0] data;
        int         rvd;     // rvalid delay after mem_req, -1 = never
        logic       hold;    // keep offering OUT while busy
        int         lat;     // cycles from accept edge to done
        logic [7:0] acc;
        logic       c;
        logic       z;
        logic       err;
        int         outv;
        logic [7:0] out;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] data,
                            input int rvd, input logic hold,
                            output int lat, output logic err_at_done, output int reqs,
                            output int outvs, output int busy_ready, output logic ready_at_done);
        int req_k;
        lat = -1; err_at_done = 1'b0; reqs = 0; outvs = 0; busy_ready = 0;
        ready_at_done = 1'b0; req_k = -100;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_addr = addr; mem_rdata = data;
        tick();
        cmd_valid = hold; cmd_opcode = OP_OUT;
        for (int k = 1; k <= 40; k++) begin
            if (mem_req) begin
                reqs++;
                req_k = k;
                chk("mem_addr", 32'(mem_addr), 32'(addr));
            end
            if (out_valid) outvs++;
            mem_rvalid = (rvd >= 0) && (k == req_k + rvd);
            if (done) begin
                lat = k;
                err_at_done = err;
                ready_at_done = cmd_ready;
                break;
            end
            if (cmd_ready) busy_ready++;
            tick();
        end
        cmd_valid = 1'b0; mem_rvalid = 1'b0;
        tick();
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("outv_single_pulse", 32'(out_valid), 32'd0);
        chk("err_single_pulse", 32'(err), 32'd0);
    endtask

    initial begin
        int   lat, reqs, outvs, busy_ready, dcnt;
        logic e, rdy;

        vecs[0]  = '{OP_LDA, 8'h2A,  1, 1'b0, 4, 8'h2A, 1'b0, 1'b0, 1'b0, 0, 8'h00};
        vecs[1]  = '{OP_LDA, 8'h05,  1, 1'b0, 4, 8'h05, 1'b0, 1'b0, 1'b0, 0, 8'h00};
        vecs[2]  = '{OP_SUB, 8'h07,  1, 1'b0, 4, 8'hFE, 1'b1, 1'b0, 1'b0, 0, 8'h00};
        vecs[3]  = '{OP_ADD, 8'h02,  2, 1'b0, 5, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h00};
        vecs[4]  = '{OP_LDA, 8'hFF,  1, 1'b0, 4, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 8'h00};
        vecs[5]  = '{OP_ADD, 8'h01,  1, 1'b0, 4, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h00};
        vecs[6]  = '{OP_OUT, 8'h00, -1, 1'b0, 1, 8'h00, 1'b1, 1'b1, 1'b0, 1, 8'h00};
        vecs[7]  = '{OP_LDA, 8'h3C,  3, 1'b0, 6, 8'h3C, 1'b1, 1'b0, 1'b0, 0, 8'h00};
        vecs[8]  = '{OP_OUT, 8'h00, -1, 1'b0, 1, 8'h3C, 1'b1, 1'b0, 1'b0, 1, 8'h3C};
        vecs[9]  = '{OP_NOP, 8'h00, -1, 1'b0, 1, 8'h3C, 1'b1, 1'b0, 1'b0, 0, 8'h3C};
        vecs[10] = '{4'h7,   8'h00, -1, 1'b0, 1, 8'h3C, 1'b1, 1'b0, 1'b1, 0, 8'h3C};
        vecs[11] = '{OP_SUB, 8'h3C,  1, 1'b0, 4, 8'h00, 1'b0, 1'b1, 1'b0, 0, 8'h3C};
        vecs[12] = '{OP_ADD, 8'h80,  1, 1'b1, 4, 8'h80, 1'b0, 1'b0, 1'b0, 0, 8'h3C};
        vecs[13] = '{OP_ADD, 8'h80,  1, 1'b0, 4, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h3C};
        vecs[14] = '{OP_LDA, 8'h00,  1, 1'b0, 4, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h3C};
        vecs[15] = '{OP_SUB, 8'h01,  1, 1'b0, 4, 8'hFF, 1'b1, 1'b0, 1'b0, 0, 8'h3C};
        vecs[16] = '{4'hF,   8'h00, -1, 1'b0, 1, 8'hFF, 1'b1, 1'b0, 1'b1, 0, 8'h3C};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_acc", 32'(acc), 32'h00);
        chk("rst_carry", 32'(carry_flag), 32'd0);
        chk("rst_zero", 32'(zero_flag), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'h00);
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Table-driven instruction stream
        for (int i = 0; i < 17; i++) begin
            do_instr(vecs[i].op, 4'(i), vecs[i].data, vecs[i].rvd, vecs[i].hold,
                     lat, e, reqs, outvs, busy_ready, rdy);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_acc", i), 32'(acc), 32'(vecs[i].acc));
            chk($sformatf("v%0d_carry", i), 32'(carry_flag), 32'(vecs[i].c));
            chk($sformatf("v%0d_zero", i), 32'(zero_flag), 32'(vecs[i].z));
            chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
            chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].out));
            chk($sformatf("v%0d_out_valid_cnt", i), 32'(outvs), 32'(vecs[i].outv));
            chk($sformatf("v%0d_mem_req_cnt", i), 32'(reqs), is_mem_op(vecs[i].op) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_busy_ready", i), 32'(busy_ready), 32'd0);
            chk($sformatf("v%0d_ready_at_done", i), 32'(rdy), 32'd1);
        end

        // mem_rvalid while idle must not load the operand (last loaded 0x01)
        mem_rvalid = 1'b1; mem_rdata = 8'h99;
        tick();
        mem_rvalid = 1'b0;
        tick();
        chk("idle_rvalid_ignored", 32'(alu_b), 32'h01);

        // Fetch timeout: FETCH + 15 WAIT cycles, then err+done
        do_instr(OP_ADD, 4'h9, 8'h11, -1, 1'b0, lat, e, reqs, outvs, busy_ready, rdy);
        chk("tmo_latency", 32'(lat), 32'd17);
        chk("tmo_err", 32'(e), 32'd1);
        chk("tmo_acc", 32'(acc), 32'hFF);
        chk("tmo_carry", 32'(carry_flag), 32'd1);
        chk("tmo_zero", 32'(zero_flag), 32'd0);
        chk("tmo_ready", 32'(rdy), 32'd1);

        // rvalid on the final WAIT cycle wins over the timeout
        do_instr(OP_ADD, 4'hA, 8'h02, 15, 1'b0, lat, e, reqs, outvs, busy_ready, rdy);
        chk("lastwait_latency", 32'(lat), 32'd18);
        chk("lastwait_err", 32'(e), 32'd0);
        chk("lastwait_acc", 32'(acc), 32'h01);
        chk("lastwait_carry", 32'(carry_flag), 32'd1);
        chk("lastwait_zero", 32'(zero_flag), 32'd0);

        // Reset while in WAIT, then a late rvalid
        cmd_valid = 1'b1; cmd_opcode = OP_ADD; cmd_addr = 4'h5;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("midrst_in_wait", 32'(cmd_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dcnt = 0;
        mem_rvalid = 1'b1; mem_rdata = 8'h55;
        for (int k = 0; k < 6; k++) begin
            tick();
            mem_rvalid = 1'b0;
            if (done) dcnt++;
        end
        chk("midrst_done_cnt", 32'(dcnt), 32'd0);
        chk("midrst_acc", 32'(acc), 32'h00);
        chk("midrst_carry", 32'(carry_flag), 32'd0);
        chk("midrst_zero", 32'(zero_flag), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'h00);
        chk("midrst_alu_b", 32'(alu_b), 32'h00);
        chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
